// File: rtl/reg_fifo_rst_y_mode_a.sv
// Flip-flop FIFO with valid/ready on both ends and first-word-fall-through
// read data. Any depth from 1 to 64 is allowed, including non-powers of two.
module reg_fifo_rst_y_mode_a #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_wr_valid,
   output logic                  o_wr_ready,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   output logic                  o_rd_valid,
   input  logic                  i_rd_ready,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   output logic [CNT_WIDTH-1:0]  o_count
);

   localparam int PTR_WIDTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(FIFO_DEPTH - 1);
   localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_WIDTH-1:0]  wr_ptr;
   logic [PTR_WIDTH-1:0]  rd_ptr;
   logic [CNT_WIDTH-1:0]  count;
   logic                  push;
   logic                  pop;

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; ready/valid outputs depend on registered count only.
   assign o_wr_ready = (count != FULL_CNT);
   assign o_rd_valid = (count != '0);
   assign o_rd_data  = mem[rd_ptr];
   assign o_count    = count;

   assign push = i_wr_valid && o_wr_ready;
   assign pop  = o_rd_valid && i_rd_ready;

   // Explicit wrap compare since the depth may not be a power of two.
   function automatic logic [PTR_WIDTH-1:0] ptr_next(input logic [PTR_WIDTH-1:0] ptr);
      return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
   endfunction

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_next(wr_ptr);
         if (pop)  rd_ptr <= ptr_next(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else if (push) begin
         mem[wr_ptr] <= i_wr_data;
      end
   end

`ifndef RTL_SYN
   logic                  hold_q;
   logic [DATA_WIDTH-1:0] hold_data_q;

   // hold_q remembers that the head was offered but not taken last cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hold_q      <= 1'b0;
         hold_data_q <= '0;
      end else begin
         if ($isunknown(i_wr_valid) || $isunknown(i_rd_ready))
            $fatal(1, "reg_fifo: X on i_wr_valid or i_rd_ready");
         if (push && $isunknown(i_wr_data))
            $fatal(1, "reg_fifo: X on i_wr_data during push");
         if (count > FULL_CNT)
            $fatal(1, "reg_fifo: count above depth");
         if (hold_q && (o_rd_data != hold_data_q))
            $fatal(1, "reg_fifo: o_rd_data changed while held");
         hold_q      <= o_rd_valid && !i_rd_ready;
         hold_data_q <= o_rd_data;
      end
   end
`endif

endmodule

// File: tb/tb_reg_fifo_rst_y_mode_a.sv
// Bench for reg_fifo_rst_y_mode_a: a depth-4 and a depth-3 instance checked
// against queue models of FIFO behaviour.
module tb_reg_fifo_rst_y_mode_a;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;

   logic          wv4 = 1'b0, rr4 = 1'b0;
   logic [DW-1:0] wd4 = '0;
   logic          wrdy4, rvld4;
   logic [DW-1:0] rd4;
   logic [2:0]    cnt4;

   logic          wv3 = 1'b0, rr3 = 1'b0;
   logic [DW-1:0] wd3 = '0;
   logic          wrdy3, rvld3;
   logic [DW-1:0] rd3;
   logic [1:0]    cnt3;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] exp_q4[$];
   logic [DW-1:0] exp_q3[$];

   reg_fifo_rst_y_mode_a #(.DATA_WIDTH(DW), .FIFO_DEPTH(4)) u_dut4 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_wr_valid(wv4), .o_wr_ready(wrdy4), .i_wr_data(wd4),
      .o_rd_valid(rvld4), .i_rd_ready(rr4), .o_rd_data(rd4), .o_count(cnt4)
   );

   reg_fifo_rst_y_mode_a #(.DATA_WIDTH(DW), .FIFO_DEPTH(3)) u_dut3 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_wr_valid(wv3), .o_wr_ready(wrdy3), .i_wr_data(wd3),
      .o_rd_valid(rvld3), .i_rd_ready(rr3), .o_rd_data(rd3), .o_count(cnt3)
   );

   always #5 clk = ~clk;

   // Drive one cycle on the depth-4 instance (called at a falling edge) and
   // advance the model with the FIFO rules; returns at the next falling edge.
   task automatic step4(input logic wv, input logic rr, input logic [DW-1:0] d);
      bit can_push, can_pop;
      wv4 = wv; rr4 = rr; wd4 = d;
      can_push = exp_q4.size() < 4;
      can_pop  = exp_q4.size() > 0;
      @(posedge clk);
      if (rr && can_pop) void'(exp_q4.pop_front());
      if (wv && can_push) exp_q4.push_back(d);
      @(negedge clk);
      wv4 = 1'b0; rr4 = 1'b0;
   endtask

   task automatic step3(input logic wv, input logic rr, input logic [DW-1:0] d);
      bit can_push, can_pop;
      wv3 = wv; rr3 = rr; wd3 = d;
      can_push = exp_q3.size() < 3;
      can_pop  = exp_q3.size() > 0;
      @(posedge clk);
      if (rr && can_pop) void'(exp_q3.pop_front());
      if (wv && can_push) exp_q3.push_back(d);
      @(negedge clk);
      wv3 = 1'b0; rr3 = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (wrdy4 !== 1'b1) begin bad++; $display("FAIL reset_wr_ready4 got=%b exp=1", wrdy4); end
      total++; if (rvld4 !== 1'b0) begin bad++; $display("FAIL reset_rd_valid4 got=%b exp=0", rvld4); end
      total++; if (rd4 !== '0) begin bad++; $display("FAIL reset_rd_data4 got=%h exp=0", rd4); end
      total++; if (cnt4 !== 3'd0) begin bad++; $display("FAIL reset_count4 got=%0d exp=0", cnt4); end
      total++; if (wrdy3 !== 1'b1) begin bad++; $display("FAIL reset_wr_ready3 got=%b exp=1", wrdy3); end
      total++; if (rvld3 !== 1'b0) begin bad++; $display("FAIL reset_rd_valid3 got=%b exp=0", rvld3); end
      total++; if (cnt3 !== 2'd0) begin bad++; $display("FAIL reset_count3 got=%0d exp=0", cnt3); end
      rst_n = 1'b1;
      // Put some data in, then reset mid-run.
      step4(1'b1, 1'b0, DW'($urandom));
      step4(1'b1, 1'b0, DW'($urandom));
      step4(1'b1, 1'b0, DW'($urandom));
      total++; if (cnt4 !== 3'd3) begin bad++; $display("FAIL prefill_count got=%0d exp=3", cnt4); end
      rst_n = 1'b0;
      exp_q4.delete();
      @(negedge clk);
      total++; if (cnt4 !== 3'd0) begin bad++; $display("FAIL midrun_reset_count got=%0d exp=0", cnt4); end
      total++; if (rd4 !== '0) begin bad++; $display("FAIL midrun_reset_data got=%h exp=0", rd4); end
      rst_n = 1'b1;
   endtask

   task automatic test_fill();
      logic [DW-1:0] vals [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
      for (int i = 0; i < 4; i++) begin
         step4(1'b1, 1'b0, vals[i]);
         total++; if (cnt4 !== 3'(i + 1)) begin bad++; $display("FAIL fill_count got=%0d exp=%0d", cnt4, i + 1); end
         total++; if (rd4 !== 32'h11) begin bad++; $display("FAIL fill_head got=%h exp=11", rd4); end
         total++; if (rvld4 !== 1'b1) begin bad++; $display("FAIL fill_rd_valid got=%b exp=1", rvld4); end
      end
      total++; if (wrdy4 !== 1'b0) begin bad++; $display("FAIL full_wr_ready got=%b exp=0", wrdy4); end
      step4(1'b1, 1'b0, 32'h55);
      total++; if (cnt4 !== 3'd4) begin bad++; $display("FAIL overflow_count got=%0d exp=4", cnt4); end
      total++; if (rd4 !== 32'h11) begin bad++; $display("FAIL overflow_head got=%h exp=11", rd4); end
   endtask

   task automatic test_drain();
      logic [DW-1:0] vals [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
      for (int i = 0; i < 5; i++) begin
         if (i < 4) begin
            total++; if (rvld4 !== 1'b1 || rd4 !== vals[i]) begin
               bad++; $display("FAIL drain_order valid=%b got=%h exp=%h", rvld4, rd4, vals[i]);
            end
         end
         step4(1'b0, 1'b1, '0);
      end
      total++; if (rvld4 !== 1'b0) begin bad++; $display("FAIL drain_rd_valid got=%b exp=0", rvld4); end
      total++; if (cnt4 !== 3'd0) begin bad++; $display("FAIL drain_count got=%0d exp=0", cnt4); end
      total++; if (wrdy4 !== 1'b1) begin bad++; $display("FAIL drain_wr_ready got=%b exp=1", wrdy4); end
      // Read pointer wrapped back to slot 0, which still holds the first word.
      total++; if (rd4 !== 32'h11) begin bad++; $display("FAIL drain_stale got=%h exp=11", rd4); end
   endtask

   task automatic test_streaming();
      int next_exp = 0;
      for (int i = 0; i < 100; i++) begin
         if (i > 0) begin
            total++; if (cnt4 !== 3'd1) begin bad++; $display("FAIL stream_count cyc=%0d got=%0d exp=1", i, cnt4); end
         end
         if (rvld4 === 1'b1) begin
            total++; if (rd4 !== DW'(next_exp)) begin bad++; $display("FAIL stream_data got=%0d exp=%0d", rd4, next_exp); end
            next_exp++;
         end
         step4(1'b1, 1'b1, DW'(i));
      end
      if (rvld4 === 1'b1) begin
         total++; if (rd4 !== DW'(next_exp)) begin bad++; $display("FAIL stream_data got=%0d exp=%0d", rd4, next_exp); end
         next_exp++;
      end
      step4(1'b0, 1'b1, '0);
      total++; if (next_exp != 100) begin bad++; $display("FAIL stream_total got=%0d exp=100", next_exp); end
      total++; if (cnt4 !== 3'd0) begin bad++; $display("FAIL stream_end_count got=%0d exp=0", cnt4); end
   endtask

   task automatic test_full_simultaneous();
      logic [DW-1:0] ord [4] = '{32'hA2, 32'hA3, 32'hA4, 32'hAA};
      step4(1'b1, 1'b0, 32'hA1);
      step4(1'b1, 1'b0, 32'hA2);
      step4(1'b1, 1'b0, 32'hA3);
      step4(1'b1, 1'b0, 32'hA4);
      step4(1'b1, 1'b1, 32'hAA);
      total++; if (cnt4 !== 3'd3) begin bad++; $display("FAIL fullsim_count got=%0d exp=3", cnt4); end
      total++; if (wrdy4 !== 1'b1) begin bad++; $display("FAIL fullsim_wr_ready got=%b exp=1", wrdy4); end
      total++; if (rd4 !== 32'hA2) begin bad++; $display("FAIL fullsim_head got=%h exp=a2", rd4); end
      step4(1'b1, 1'b0, 32'hAA);
      for (int i = 0; i < 4; i++) begin
         total++; if (rd4 !== ord[i] || rd4 !== exp_q4[0]) begin
            bad++; $display("FAIL fullsim_order got=%h exp=%h", rd4, ord[i]);
         end
         step4(1'b0, 1'b1, '0);
      end
      total++; if (rvld4 !== 1'b0) begin bad++; $display("FAIL fullsim_empty got=%b exp=0", rvld4); end
   endtask

   task automatic test_async_reset();
      step4(1'b1, 1'b0, 32'hC1);
      step4(1'b1, 1'b0, 32'hC2);
      total++; if (cnt4 !== 3'd2) begin bad++; $display("FAIL areset_pre_count got=%0d exp=2", cnt4); end
      #2 rst_n = 1'b0;
      #1;
      exp_q4.delete();
      total++; if (rvld4 !== 1'b0) begin bad++; $display("FAIL areset_rd_valid got=%b exp=0", rvld4); end
      total++; if (cnt4 !== 3'd0) begin bad++; $display("FAIL areset_count got=%0d exp=0", cnt4); end
      total++; if (rd4 !== '0) begin bad++; $display("FAIL areset_rd_data got=%h exp=0", rd4); end
      @(negedge clk);
      rst_n = 1'b1;
      step4(1'b1, 1'b0, 32'h5A);
      total++; if (rvld4 !== 1'b1 || rd4 !== 32'h5A) begin
         bad++; $display("FAIL areset_new_data valid=%b got=%h exp=5a", rvld4, rd4);
      end
      total++; if (cnt4 !== 3'd1) begin bad++; $display("FAIL areset_new_count got=%0d exp=1", cnt4); end
      step4(1'b0, 1'b1, '0);
      total++; if (rvld4 !== 1'b0) begin bad++; $display("FAIL areset_no_old got=%b exp=0", rvld4); end
   endtask

   task automatic test_wrap_depth3();
      logic wv, rr;
      for (int i = 0; i < 1000; i++) begin
         total++; if (cnt3 !== 2'(exp_q3.size())) begin
            bad++; $display("FAIL wrap_count cyc=%0d got=%0d exp=%0d", i, cnt3, exp_q3.size());
         end
         total++; if (wrdy3 !== (exp_q3.size() != 3) || rvld3 !== (exp_q3.size() != 0)) begin
            bad++; $display("FAIL wrap_flags cyc=%0d wr_ready=%b rd_valid=%b size=%0d", i, wrdy3, rvld3, exp_q3.size());
         end
         if (exp_q3.size() != 0) begin
            total++; if (rd3 !== exp_q3[0]) begin
               bad++; $display("FAIL wrap_data cyc=%0d got=%h exp=%h", i, rd3, exp_q3[0]);
            end
         end
         wv = ($urandom_range(0, 99) < 60);
         rr = ($urandom_range(0, 99) < 50);
         step3(wv, rr, DW'($urandom));
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_fill();
      test_drain();
      test_streaming();
      test_full_simultaneous();
      test_async_reset();
      test_wrap_depth3();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reg_fifo_rst_y_mode_a.md
Name: reg_fifo_rst_y_mode_a

Overview:
- Register-based synchronous FIFO with valid/ready handshakes on both ends.
- The producer writes on one side and the consumer reads on the other, so the flop library gains a buffering stage with a read side.
- Used between pipeline stages that need decoupling or rate absorption.
- Single clock domain. Storage is flip-flops only, with no SRAM macro.

Parameters:
DATA_WIDTH, 32, width of each entry in bits
FIFO_DEPTH, 4, number of entries; legal range is 1 to 64, any integer (not restricted to powers of two)
CNT_WIDTH, $clog2(FIFO_DEPTH + 1), width of o_count; derived, not overridden

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  reset, asynchronous assert, active-low
i_wr_valid  input  1  producer presents i_wr_data
o_wr_ready  output  1  FIFO can accept a write this cycle
i_wr_data  input  DATA_WIDTH  write data
o_rd_valid  output  1  o_rd_data holds the oldest entry
i_rd_ready  input  1  consumer takes o_rd_data this cycle
o_rd_data  output  DATA_WIDTH  head entry, first-word-fall-through
o_count  output  CNT_WIDTH  number of stored entries

Interface (already decided):
- One clock: i_clk.
- Reset i_rst_n is asynchronous and active-low.

Behaviour:
- Push: occurs on a rising i_clk edge when i_wr_valid && o_wr_ready. The data is written to mem[wr_ptr], and wr_ptr advances.
- Pop: occurs on a rising i_clk edge when o_rd_valid && i_rd_ready. rd_ptr advances. There is no read-data register.
- Pointer wrap: a pointer at FIFO_DEPTH-1 returns to 0. Wrap is an explicit compare, not binary overflow, because FIFO_DEPTH need not be a power of two.
- Output decode, all taken from registered state only:
  - o_wr_ready = (count != FIFO_DEPTH)
  - o_rd_valid = (count != 0)
  - o_rd_data = mem[rd_ptr]
  - o_count = count
- No combinational path from i_wr_valid or i_rd_ready to any output.
- Latency: data pushed at edge N is visible on o_rd_data with o_rd_valid=1 after edge N, so a pop is possible at edge N+1. There is no bypass of an empty FIFO.
- Count update:
  - +1 on push only
  - -1 on pop only
  - unchanged on push+pop together, or on neither
- Full with simultaneous i_wr_valid and i_rd_ready:
  - The pop happens.
  - The push is refused, because o_wr_ready=0 in that cycle.
  - The next cycle shows count = FIFO_DEPTH-1 and o_wr_ready=1.
- Empty with i_rd_ready=1: no pop, and rd_ptr is unchanged.
- Empty with i_wr_valid=1: the push happens, and the read side stays idle that cycle.
- Hold rule: while o_rd_valid && !i_rd_ready, o_rd_data is stable, including across pushes into other slots.
- Reset, applied immediately on the falling edge of i_rst_n (mid-operation included):
  - wr_ptr, rd_ptr and count go to 0.
  - All mem entries clear to 0.
  - Outputs after reset: o_wr_ready=1, o_rd_valid=0, o_rd_data=0, o_count=0.
  - Any in-flight transfer is dropped, and stored data is discarded.
  - Release of i_rst_n is synchronous to the design by contract: no push or pop occurs on the release edge's own cycle unless the inputs request it after release.
- FIFO_DEPTH=1: behaves as a single-entry handshake register. It alternates full/empty, so throughput is at most one transfer per 2 cycles.
- Sim-only checks, excluded under RTL_SYN:
  - X on i_wr_data when a push occurs is fatal.
  - X on i_wr_valid or i_rd_ready out of reset is fatal.
  - count > FIFO_DEPTH is fatal.
  - A change in o_rd_data while o_rd_valid && !i_rd_ready is fatal.

Test Plan:
- Reset/fill (FIFO_DEPTH=4)
  - Stimulus: assert i_rst_n=0 mid-run, release, then push 0x11, 0x22, 0x33, 0x44 on consecutive cycles with i_rd_ready=0.
  - Required: o_count goes 1,2,3,4; o_wr_ready=0 after the 4th push; o_rd_data=0x11 throughout; a 5th push of 0x55 is not accepted.
- Drain/order
  - Stimulus: from full, i_rd_ready=1 for 5 cycles.
  - Required: o_rd_data reads 0x11, 0x22, 0x33, 0x44 in that order; then o_rd_valid=0, o_count=0, o_rd_data holds the stale value with valid low.
- Streaming
  - Stimulus: i_wr_valid=1 and i_rd_ready=1 continuously with an incrementing pattern 0..99.
  - Required: steady state o_count=1 after the first cycle; all 100 values arrive in order; no cycle loses a value.
- Full simultaneous
  - Stimulus: fill to 4, then one cycle with i_wr_valid=1 (0xAA) and i_rd_ready=1.
  - Required: the head pops; 0xAA is not written; next cycle o_count=3 and o_wr_ready=1.
  - Then push 0xAA. Required: it emerges after the 3 older entries.
- Wrap with non-power-of-two depth
  - Stimulus: FIFO_DEPTH=3; push/pop a random valid/ready pattern for 1000 cycles against a scoreboard model.
  - Required: zero mismatches; pointers wrap 2→0; o_count never exceeds 3.
- Async reset mid-burst
  - Stimulus: with 2 entries held, pull i_rst_n low between clock edges.
  - Required: o_rd_valid=0, o_count=0, o_rd_data=0 before the next rising edge.
  - After release, push 0x5A. Required: the read returns 0x5A with no old data.
